intr_controller: RTL and testbench

Prioritised interrupt controller between the interrupt sources (timer `out_timer`, external lines) and the CPU fetch stage. It latches rising edges on its request lines into pending bits and applies a mask. It presents the highest-priority eligible request to the CPU, together with a 10-bit handler address that matches the PC/stack width. It tracks in-service state until the CPU signals return-from-interrupt; the CPU's PC mux and stack push/pop consume its outputs.

---
 rtl/intr_controller.sv | 116 +++++++++++
 tb/tb_intr_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_controller.sv
// Prioritised interrupt controller: edge-latched pending bits, mask, in-service tracking.
// Optional build macro INTR_NESTING_EN enables preemption by strictly higher-priority sources.
module intr_controller #(
  parameter int         NSRC       = 4,
  parameter logic [9:0] VEC_BASE   = 10'h3C0,
  parameter logic [9:0] VEC_STRIDE = 10'd16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  input  logic            cpu_take,
  input  logic            reti,
  output logic            intr_req,
  output logic [9:0]      intr_vec,
  output logic [2:0]      intr_id,
  output logic            in_service,
  output logic            err
);

  logic [NSRC-1:0] irq_q, irq_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d_int;
  logic [NSRC-1:0] isr_q, isr_d;
  logic            err_q, err_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig_now;
  logic [NSRC-1:0] isr_post;
  logic [NSRC-1:0] elig_post;
  logic [NSRC-1:0] take_onehot;
  logic [2:0]      sel_now;
  logic [2:0]      sel_post;
  logic            take_ok;

  function automatic logic [NSRC-1:0] allowed_f(input logic [NSRC-1:0] isr);
    logic [NSRC-1:0] res;
    logic            seen;
    res  = '0;
    seen = 1'b0;
`ifdef INTR_NESTING_EN
    for (int i = 0; i < NSRC; i++) begin
      seen   = seen | isr[i];
      res[i] = ~seen;
    end
`else
    seen = |isr;
    res  = seen ? '0 : '1;
`endif
    return res;
  endfunction

  function automatic logic [NSRC-1:0] lowest_f(input logic [NSRC-1:0] v);
    logic [NSRC-1:0] res;
    res = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) res = NSRC'(1) << i;
    end
    return res;
  endfunction

  function automatic logic [2:0] index_f(input logic [NSRC-1:0] v);
    logic [2:0] res;
    res = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) res = 3'(i);
    end
    return res;
  endfunction

  // reti is resolved first, then the take uses the selection seen by the post-reti isr.
  always_comb begin
    rise        = irq_in & ~irq_q;
    irq_d       = irq_in;
    elig_now    = pending_q & mask_q & allowed_f(isr_q);
    sel_now     = index_f(elig_now);
    isr_post    = reti ? (isr_q & ~lowest_f(isr_q)) : isr_q;
    elig_post   = pending_q & mask_q & allowed_f(isr_post);
    sel_post    = index_f(elig_post);
    take_ok     = cpu_take & (|elig_post);
    take_onehot = take_ok ? lowest_f(elig_post) : '0;
    pending_d   = (pending_q & ~take_onehot) | rise;
    isr_d       = isr_post | take_onehot;
    mask_d_int  = mask_we ? mask_d : mask_q;
    err_d       = err_q | (reti & ~(|isr_q)) | (cpu_take & ~(|elig_post));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      isr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
      mask_q    <= mask_d_int;
      isr_q     <= isr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    intr_req   = |elig_now;
    intr_id    = intr_req ? sel_now : 3'd0;
    intr_vec   = VEC_BASE + 10'(intr_id) * VEC_STRIDE;
    in_service = |isr_q;
    err        = err_q;
  end

  logic unused_sel_post;
  assign unused_sel_post = ^sel_post;

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed steps plus random traffic
// compared against a priority-rule reference model.
module tb_intr_controller;
  localparam int NSRC       = 4;
  localparam int VEC_BASE   = 'h3C0;
  localparam int VEC_STRIDE = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_d;
  logic            cpu_take;
  logic            reti;
  logic            intr_req;
  logic [9:0]      intr_vec;
  logic [2:0]      intr_id;
  logic            in_service;
  logic            err;

  int evaluated = 0;
  int failures  = 0;

  bit m_prev[NSRC];
  bit m_pend[NSRC];
  bit m_mask[NSRC];
  bit m_isr[NSRC];
  bit m_err;

  always #5 clk = ~clk;

  intr_controller dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .cpu_take  (cpu_take),
    .reti      (reti),
    .intr_req  (intr_req),
    .intr_vec  (intr_vec),
    .intr_id   (intr_id),
    .in_service(in_service),
    .err       (err)
  );

  function automatic bit m_allowed(int i);
`ifdef INTR_NESTING_EN
    for (int j = 0; j <= i; j++) if (m_isr[j]) return 1'b0;
`else
    for (int j = 0; j < NSRC; j++) if (m_isr[j]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_mask[i] && m_allowed(i)) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0; m_isr[i] = 0;
    end
    m_err = 0;
  endfunction

  // Advance the model by one clock edge using the rules in order: reti, take, edges, mask.
  function automatic void m_step(logic [NSRC-1:0] irq, logic we, logic [NSRC-1:0] md,
                                 logic take, logic rt);
    int k;
    int s;
    if (rt) begin
      k = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (m_isr[i]) k = i;
      if (k < 0) m_err = 1; else m_isr[k] = 0;
    end
    s = m_sel();
    if (take) begin
      if (s < 0) m_err = 1;
      else begin
        m_pend[s] = 0;
        m_isr[s]  = 1;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
    end
    if (we) for (int i = 0; i < NSRC; i++) m_mask[i] = md[i];
  endfunction

  task automatic checkOutput(input string tag);
    int  s;
    bit  exp_req;
    int  exp_id;
    int  exp_vec;
    bit  exp_svc;
    s       = m_sel();
    exp_req = (s >= 0);
    exp_id  = exp_req ? s : 0;
    exp_vec = (VEC_BASE + exp_id * VEC_STRIDE) % 1024;
    exp_svc = 0;
    for (int i = 0; i < NSRC; i++) if (m_isr[i]) exp_svc = 1;
    evaluated++;
    assert (intr_req === exp_req) else begin
      failures++; $error("[TB] FAIL %s intr_req: got %b want %b", tag, intr_req, exp_req);
    end
    evaluated++;
    assert (intr_id === 3'(exp_id)) else begin
      failures++; $error("[TB] FAIL %s intr_id: got %0d want %0d", tag, intr_id, exp_id);
    end
    evaluated++;
    assert (intr_vec === 10'(exp_vec)) else begin
      failures++; $error("[TB] FAIL %s intr_vec: got %h want %h", tag, intr_vec, exp_vec);
    end
    evaluated++;
    assert (in_service === exp_svc) else begin
      failures++; $error("[TB] FAIL %s in_service: got %b want %b", tag, in_service, exp_svc);
    end
    evaluated++;
    assert (err === m_err) else begin
      failures++; $error("[TB] FAIL %s err: got %b want %b", tag, err, m_err);
    end
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] irq, input logic we,
                               input logic [NSRC-1:0] md, input logic take,
                               input logic rt, input string tag);
    irq_in   = irq;
    mask_we  = we;
    mask_d   = md;
    cpu_take = take;
    reti     = rt;
    @(posedge clk);
    m_step(irq, we, md, take, rt);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic resetMid(input string tag);
    #1 reset = 1'b1;
    #1 m_reset();
    checkOutput(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    int req_rises;
    bit prev_req;
    reset = 1'b1; irq_in = '0; mask_we = 0; mask_d = '0; cpu_take = 0; reti = 0;
    m_reset();
    #3 checkOutput("reset");
    #1 reset = 1'b0;

    applyStimulus(4'b0000, 1, 4'b1111, 0, 0, "mask_all");
    applyStimulus(4'b0100, 0, 4'b0000, 0, 0, "pulse2");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 0, "pulse2_hold");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "take2");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "reti2");

    applyStimulus(4'b1010, 0, 4'b0000, 0, 0, "both13");
    applyStimulus(4'b1010, 0, 4'b0000, 1, 0, "take1");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "reti1");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "take3");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "reti3");

    applyStimulus(4'b0000, 1, 4'b0000, 0, 0, "mask_none");
    applyStimulus(4'b0001, 0, 4'b0000, 0, 0, "pulse0_masked");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 0, "masked_hold");
    applyStimulus(4'b0000, 1, 4'b0001, 0, 0, "unmask0");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "take0");
    applyStimulus(4'b0000, 1, 4'b1111, 0, 1, "reti0");

    req_rises = 0;
    prev_req  = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b1000, 0, 4'b0000, c == 2, c == 5, "hold3");
      if (intr_req && !prev_req) req_rises++;
      prev_req = intr_req;
    end
    applyStimulus(4'b0000, 0, 4'b0000, 0, 0, "hold3_release");
    evaluated++;
    assert (req_rises == 1) else begin
      failures++; $error("[TB] FAIL hold3_count: got %0d requests want 1", req_rises);
    end

`ifdef INTR_NESTING_EN
    applyStimulus(4'b0100, 0, 4'b0000, 0, 0, "nest_pulse2");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "nest_take2");
    applyStimulus(4'b0001, 0, 4'b0000, 0, 0, "nest_pulse0");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "nest_take0");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "nest_reti0");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "nest_reti2");
`else
    applyStimulus(4'b0100, 0, 4'b0000, 0, 0, "flat_pulse2");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "flat_take2");
    applyStimulus(4'b0001, 0, 4'b0000, 0, 0, "flat_pulse0_blocked");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "flat_reti2");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "flat_take0");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "flat_reti0");
`endif

    applyStimulus(4'b0000, 0, 4'b0000, 0, 1, "reti_idle_err");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 0, "err_sticky");
    applyStimulus(4'b0010, 0, 4'b0000, 0, 0, "pre_reset_pulse1");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "pre_reset_take1");
    resetMid("reset_mid_service");
    applyStimulus(4'b0000, 0, 4'b0000, 1, 0, "take_idle_err");
    applyStimulus(4'b0000, 0, 4'b0000, 0, 0, "err_sticky2");

    resetMid("reset_before_random");
    applyStimulus(4'b0000, 1, 4'b1111, 0, 0, "rand_mask");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
